mem_loader: RTL

MEM_LOADER -- requirements
Module: mem_loader

---
 rtl/mem_loader_pkg.sv | 34 +++
 rtl/loader_word_asm.sv | 15 +
 rtl/mem_loader.sv | 97 +++++++++
 3 files changed

// File: rtl/mem_loader_pkg.sv
// mem_loader_pkg: state encoding and loader constants; CSUM/ERROR states exist only with MEM_LOADER_CHECKSUM_EN
package mem_loader_pkg;
    localparam int HEADER_BYTES = 4;
    localparam int STROBE_CYCLES = 3;
    typedef enum logic [3:0] {
        ADDR_H, ADDR_L, CNT_H, CNT_L, DATA_H, DATA_L, SETUP, STROBE, HOLD,
`ifdef MEM_LOADER_CHECKSUM_EN
        CSUM_H, CSUM_L, ERROR,
`endif
        DONE
    } loaderState_t;
`ifdef MEM_LOADER_CHECKSUM_EN
    localparam loaderState_t AFTER_DATA = CSUM_H;
`else
    localparam loaderState_t AFTER_DATA = DONE;
`endif
    function automatic logic isRxState(input loaderState_t s);
        return s inside {ADDR_H, ADDR_L, CNT_H, CNT_L, DATA_H, DATA_L
`ifdef MEM_LOADER_CHECKSUM_EN
            , CSUM_H, CSUM_L
`endif
        };
    endfunction
    function automatic logic isHiState(input loaderState_t s);
        return s inside {ADDR_H, CNT_H, DATA_H
`ifdef MEM_LOADER_CHECKSUM_EN
            , CSUM_H
`endif
        };
    endfunction
    function automatic logic isWriteState(input loaderState_t s);
        return s inside {SETUP, STROBE, HOLD};
    endfunction
endpackage

// File: rtl/loader_word_asm.sv
// loader_word_asm: pairs a latched high byte with the current byte into a big-endian word
module loader_word_asm (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  byteIn,
    input  logic        loadHi,
    output logic [15:0] word
);
    logic [7:0] hiByte;
    // capture the high byte; the low byte is used live when the word completes
    always_ff @(posedge clock)
        if (reset) hiByte <= '0;
        else if (loadHi) hiByte <= byteIn;
    assign word = {hiByte, byteIn};
endmodule

// File: rtl/mem_loader.sv
// mem_loader: byte-stream SRAM program loader holding the CPU in reset until done; MEM_LOADER_CHECKSUM_EN adds a trailing checksum word
module mem_loader
    import mem_loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  rxData,
    input  logic        rxValid,
    output logic        rxReady,
    output logic [15:0] memAddr,
    output logic [15:0] memData,
    output logic        memNotCS,
    output logic        memNotWE,
    output logic        memNotOE,
    output logic        busOE,
    output logic        cpuNotReset,
    output logic        done,
    output logic        error
);
    loaderState_t state, nextState;
    logic [15:0] count, word;
    logic accept;
`ifdef MEM_LOADER_CHECKSUM_EN
    logic [15:0] sum;
`endif

    assign rxReady = isRxState(state);
    assign accept = rxValid && rxReady;

    loader_word_asm wordAsm (
        .clock(clock),
        .reset(reset),
        .byteIn(rxData),
        .loadHi(accept && isHiState(state)),
        .word(word)
    );

    // state register
    always_ff @(posedge clock)
        if (reset) state <= ADDR_H;
        else state <= nextState;

    // next state: receive states advance on accepted bytes, write cycle runs unconditionally
    always_comb begin
        nextState = state;
        case (state)
            ADDR_H: nextState = accept ? ADDR_L : state;
            ADDR_L: nextState = accept ? CNT_H : state;
            CNT_H:  nextState = accept ? CNT_L : state;
            CNT_L:  nextState = accept ? (word == '0 ? AFTER_DATA : DATA_H) : state;
            DATA_H: nextState = accept ? DATA_L : state;
            DATA_L: nextState = accept ? SETUP : state;
            SETUP:  nextState = STROBE;
            STROBE: nextState = HOLD;
            HOLD:   nextState = count == 16'd1 ? AFTER_DATA : DATA_H;
`ifdef MEM_LOADER_CHECKSUM_EN
            CSUM_H: nextState = accept ? CSUM_L : state;
            CSUM_L: nextState = accept ? (word == sum ? DONE : ERROR) : state;
`endif
            default: nextState = state;
        endcase
    end

    // address, data, remaining count and running sum
    always_ff @(posedge clock) begin
        if (reset) begin
            memAddr <= '0;
            memData <= '0;
            count <= '0;
        end else begin
            if (accept && state == ADDR_L) memAddr <= word;
            if (accept && state == CNT_L) count <= word;
            if (accept && state == DATA_L) memData <= word;
            if (state == HOLD) begin
                memAddr <= memAddr + 16'd1;
                count <= count - 16'd1;
            end
        end
    end

`ifdef MEM_LOADER_CHECKSUM_EN
    // checksum accumulates every data word as it is latched
    always_ff @(posedge clock)
        if (reset) sum <= '0;
        else if (accept && state == DATA_L) sum <= sum + word;
    assign error = state == ERROR;
`else
    assign error = 1'b0;
`endif

    assign memNotCS = !isWriteState(state);
    assign memNotWE = state != STROBE;
    assign memNotOE = 1'b1;
    assign cpuNotReset = state == DONE;
    assign busOE = !cpuNotReset;
    assign done = state == DONE;
endmodule
